// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, FSM state codes, address map and access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] LEDR_ADDR = 32'h1000_0000;
    localparam logic [31:0] LEDG_ADDR = 32'h1000_1000;
    localparam logic [31:0] SW_ADDR   = 32'h1001_0000;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unused encodings (011, 110, 111) fall through to word accesses.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enabled synchronous-read data SRAM, WORDS x 32, contents not reset.
module lsu_dmem #(
    parameter int unsigned WORDS = 512,
    localparam int unsigned AW = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE -> ACCESS -> RESP over DMEM plus LEDR/LEDG/SW registers.
// Define LSU_MISALIGN_TRAP_EN to flag and suppress misaligned H/W accesses instead of aligning down.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wren,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_misaligned,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    logic [1:0]    state, state_next;
    logic [31:0]   addr_q, wdata_q;
    logic          wren_q;
    logic [2:0]    funct3_q;
    logic [31:0]   sw_meta, sw_sync, ledr_q, ledg_q;
    logic          ready_q, rvalid_q;
    logic [31:0]   rdata_q;

    size_e         size_c;
    logic          misaligned_c;
    logic [1:0]    off_c;
    logic [3:0]    be_c;
    logic [31:0]   lane_mask_c, wdata_sh_c, rword_c, rword_sh_c, load_c, rdata_next_c;
    logic          hit_dmem_c, hit_ledr_c, hit_ledg_c, hit_sw_c;
    logic          do_write_c, dmem_we_c;
    logic [AW-1:0] dmem_addr_c;
    logic [31:0]   dmem_rdata;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (i_req) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request capture; later i_req/i_* changes are ignored until back in IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wren_q   <= 1'b0;
            funct3_q <= 3'b000;
        end else if (state == ST_IDLE && i_req) begin
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
            wren_q   <= i_wren;
            funct3_q <= i_funct3;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sw_meta <= 32'h0;
            sw_sync <= 32'h0;
        end else begin
            sw_meta <= i_io_sw;
            sw_sync <= sw_meta;
        end
    end

    // Lane/size decode, address map and load extension for the captured access.
    always_comb begin
        size_c = f3_size(funct3_q);
        off_c  = 2'b00;
        be_c   = 4'b1111;
        case (size_c)
            SZ_B: begin
                off_c = addr_q[1:0];
                be_c  = 4'b0001 << addr_q[1:0];
            end
            SZ_H: begin
                off_c = {addr_q[1], 1'b0};
                be_c  = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase

        misaligned_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_c = (size_c == SZ_H && addr_q[0]) ||
                       (size_c == SZ_W && addr_q[1:0] != 2'b00);
`endif

        lane_mask_c = 32'h0;
        for (int b = 0; b < 4; b++) lane_mask_c[8*b +: 8] = {8{be_c[b]}};
        wdata_sh_c = wdata_q << {off_c, 3'b000};

        hit_dmem_c = addr_q < DMEM_BYTES;
        hit_ledr_c = addr_q[31:2] == LEDR_ADDR[31:2];
        hit_ledg_c = addr_q[31:2] == LEDG_ADDR[31:2];
        hit_sw_c   = addr_q[31:2] == SW_ADDR[31:2];

        rword_c = 32'h0;
        if (hit_dmem_c)      rword_c = dmem_rdata;
        else if (hit_ledr_c) rword_c = ledr_q;
        else if (hit_ledg_c) rword_c = ledg_q;
        else if (hit_sw_c)   rword_c = sw_sync;
        rword_sh_c = rword_c >> {off_c, 3'b000};

        case (size_c)
            SZ_B:    load_c = funct3_q[2] ? {24'h0, rword_sh_c[7:0]}
                                          : {{24{rword_sh_c[7]}}, rword_sh_c[7:0]};
            SZ_H:    load_c = funct3_q[2] ? {16'h0, rword_sh_c[15:0]}
                                          : {{16{rword_sh_c[15]}}, rword_sh_c[15:0]};
            default: load_c = rword_sh_c;
        endcase
        rdata_next_c = (wren_q || misaligned_c) ? 32'h0 : load_c;

        do_write_c  = (state == ST_ACCESS) && wren_q && !misaligned_c;
        dmem_we_c   = do_write_c && hit_dmem_c;
        // Reading from i_addr while IDLE lands the SRAM word in time for the ACCESS edge.
        dmem_addr_c = (state == ST_IDLE) ? i_addr[AW+1:2] : addr_q[AW+1:2];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            ledr_q   <= 32'h0;
            ledg_q   <= 32'h0;
        end else begin
            ready_q  <= state_next == ST_IDLE;
            rvalid_q <= state == ST_ACCESS;
            if (state == ST_ACCESS) rdata_q <= rdata_next_c;
            if (do_write_c && hit_ledr_c) ledr_q <= (ledr_q & ~lane_mask_c) | (wdata_sh_c & lane_mask_c);
            if (do_write_c && hit_ledg_c) ledg_q <= (ledg_q & ~lane_mask_c) | (wdata_sh_c & lane_mask_c);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) mis_q <= 1'b0;
        else         mis_q <= (state == ST_ACCESS) && misaligned_c;
    end

    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

    lsu_dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .i_clk (i_clk),
        .addr  (dmem_addr_c),
        .we    (dmem_we_c),
        .be    (be_c),
        .wdata (wdata_sh_c),
        .rdata (dmem_rdata)
    );

    assign o_ready   = ready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses against a byte-level model.
module tb_lsu;
    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] o_rdata;
    logic        o_rvalid;
    logic        o_misaligned;
    logic [31:0] i_io_sw;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [2048];
    logic [31:0] m_ledr = 32'h0;
    logic [31:0] m_ledg = 32'h0;

    always #5 i_clk = ~i_clk;

    lsu #(.DMEM_WORDS(512)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .o_ready      (o_ready),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_wren       (i_wren),
        .i_funct3     (i_funct3),
        .o_rdata      (o_rdata),
        .o_rvalid     (o_rvalid),
        .o_misaligned (o_misaligned),
        .i_io_sw      (i_io_sw),
        .o_io_ledr    (o_io_ledr),
        .o_io_ledg    (o_io_ledg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = unmapped, 1 = DMEM, 2 = LEDR, 3 = LEDG, 4 = SW
    function automatic int region_of(input logic [31:0] a);
        if (a < 32'd2048)                            return 1;
        if ((a & ~32'h3) == 32'h1000_0000)           return 2;
        if ((a & ~32'h3) == 32'h1000_1000)           return 3;
        if ((a & ~32'h3) == 32'h1001_0000)           return 4;
        return 0;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        int k;
        k = int'(a & 32'h3);
        case (region_of(a))
            1:       return m_mem[a[10:0]];
            2:       return m_ledr[8*k +: 8];
            3:       return m_ledg[8*k +: 8];
            4:       return i_io_sw[8*k +: 8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void put_byte(input logic [31:0] a, input logic [7:0] d);
        int k;
        k = int'(a & 32'h3);
        case (region_of(a))
            1:       m_mem[a[10:0]] = d;
            2:       m_ledr[8*k +: 8] = d;
            3:       m_ledg[8*k +: 8] = d;
            default: ;
        endcase
    endfunction

    // Applies one access to the model and returns the expected response.
    function automatic void model_access(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                                         input logic [2:0] f3, output logic [31:0] rd, output logic mis);
        int size;
        logic [31:0] ea;
        logic [31:0] v;
        size = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (a % size) != 0;
`endif
        ea = a - (a % size);
        rd = 32'h0;
        if (mis) return;
        if (wr) begin
            for (int i = 0; i < size; i++) put_byte(ea + i, wd[8*i +: 8]);
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = get_byte(ea + i);
            if (size == 1)      rd = f3[2] ? v : {{24{v[7]}}, v[7:0]};
            else if (size == 2) rd = f3[2] ? v : {{16{v[15]}}, v[15:0]};
            else                rd = v;
        end
    endfunction

    // One full transaction; inputs are scrambled while busy to show they are ignored.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                          input logic [2:0] f3, input string tag);
        logic [31:0] erd;
        logic        emis;
        int          n;
        n = 0;
        while (!o_ready && n < 10) begin
            @(posedge i_clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(o_ready), 32'h1);
        i_req    = 1'b1;
        i_addr   = a;
        i_wdata  = wd;
        i_wren   = wr;
        i_funct3 = f3;
        model_access(a, wd, wr, f3, erd, emis);
        @(posedge i_clk); #1;
        check({tag, "_busy"}, {30'h0, o_ready, o_rvalid}, 32'h0);
        i_addr   = $urandom;
        i_wdata  = $urandom;
        i_wren   = 1'($urandom_range(0, 1));
        i_funct3 = 3'($urandom_range(0, 7));
        @(posedge i_clk); #1;
        check({tag, "_rvalid"}, 32'(o_rvalid), 32'h1);
        check({tag, "_rdata"}, o_rdata, erd);
        check({tag, "_mis"}, 32'(o_misaligned), 32'(emis));
        @(posedge i_clk); #1;
        i_req = 1'b0;
        check({tag, "_done"}, {30'h0, o_ready, o_rvalid}, 32'h2);
        check({tag, "_ledr"}, o_io_ledr, m_ledr);
        check({tag, "_ledg"}, o_io_ledg, m_ledg);
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        i_reset  = 1'b1;
        i_req    = 1'b0;
        i_addr   = 32'h0;
        i_wdata  = 32'h0;
        i_wren   = 1'b0;
        i_funct3 = 3'b000;
        i_io_sw  = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'h1);
        check("rst_rvalid", 32'(o_rvalid), 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_mis", 32'(o_misaligned), 32'h0);
        check("rst_ledr", o_io_ledr, 32'h0);
        check("rst_ledg", o_io_ledg, 32'h0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // Fill the low 1 KiB and the last word so random loads see defined data.
        for (int w = 0; w < 256; w++) access(32'(w * 4), $urandom, 1'b1, F3_W, "init");
        access(32'h7FC, $urandom, 1'b1, F3_W, "init_top");

        access(32'h100, 32'h0000_0034, 1'b1, F3_W, "sw100");
        access(32'h100, 32'h0, 1'b0, F3_W, "lw100");
        check("lw100_const", o_rdata, 32'h0000_0034);

        access(32'h200, 32'h8000_80F0, 1'b1, F3_W, "sw200");
        access(32'h200, 32'h0, 1'b0, F3_B, "lb200");
        check("lb200_const", o_rdata, 32'hFFFF_FFF0);
        access(32'h200, 32'h0, 1'b0, F3_BU, "lbu200");
        check("lbu200_const", o_rdata, 32'h0000_00F0);
        access(32'h202, 32'h0, 1'b0, F3_H, "lh202");
        check("lh202_const", o_rdata, 32'hFFFF_8000);

        access(32'h1000_0001, 32'h0000_00AB, 1'b1, F3_B, "sb_ledr");
        check("sb_ledr_const", o_io_ledr, 32'h0000_AB00);
        access(32'h1000_0000, 32'h0, 1'b0, F3_W, "lw_ledr");
        check("lw_ledr_const", o_rdata, 32'h0000_AB00);

        i_io_sw = 32'h5;
        repeat (3) @(posedge i_clk);
        #1;
        access(SW_ADDR, 32'h0, 1'b0, F3_W, "lw_sw");
        check("lw_sw_const", o_rdata, 32'h5);
        access(32'h2000_0000, 32'h0, 1'b0, F3_W, "lw_unmapped");
        access(32'h2000_0000, 32'hCAFE_F00D, 1'b1, F3_W, "sw_unmapped");
        access(32'h0, 32'h0, 1'b0, F3_W, "lw_word0");
        access(SW_ADDR, 32'hFFFF_FFFF, 1'b1, F3_W, "sw_to_sw");
        access(SW_ADDR, 32'h0, 1'b0, F3_W, "lw_sw_again");

        access(32'h102, 32'h1234_5678, 1'b1, F3_W, "sw102");
        access(32'h100, 32'h0, 1'b0, F3_W, "lw100_after");
        access(32'h101, 32'h0, 1'b0, F3_H, "lh101");

        // Reset during ACCESS of a store to LEDG.
        access(LEDG_ADDR, 32'h0000_FFFF, 1'b1, F3_W, "ledg_pre");
        i_req    = 1'b1;
        i_addr   = LEDG_ADDR;
        i_wdata  = 32'h1;
        i_wren   = 1'b1;
        i_funct3 = F3_W;
        @(posedge i_clk); #1;
        i_req   = 1'b0;
        i_reset = 1'b1;
        #1;
        check("rst_acc_ready", 32'(o_ready), 32'h1);
        check("rst_acc_ledg", o_io_ledg, 32'h0);
        check("rst_acc_ledr", o_io_ledr, 32'h0);
        m_ledr = 32'h0;
        m_ledg = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check("rst_acc_no_rvalid", 32'(o_rvalid), 32'h0);
        end
        i_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk); #1;
            check("post_rst_no_rvalid", 32'(o_rvalid), 32'h0);
        end
        access(LEDG_ADDR, 32'h0, 1'b0, F3_W, "lw_ledg_post_rst");

        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 1023));
                5:       a = 32'h7FC + 32'($urandom_range(0, 3));
                6:       a = 32'h800 + 32'($urandom_range(0, 15));
                7:       a = ($urandom_range(0, 1) != 0 ? LEDR_ADDR : LEDG_ADDR) + 32'($urandom_range(0, 3));
                8:       a = SW_ADDR + 32'($urandom_range(0, 3));
                default: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
            endcase
            if (k % 25 == 0) begin
                i_io_sw = $urandom;
                repeat (3) @(posedge i_clk);
                #1;
            end
            access(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rand");
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 512, giving data memory depth in 32-bit words (2 KiB).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_req  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port i_addr  input  32  byte address, taken from the ALU result.
REQ-007 SHALL have port i_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port i_wren  input  1  1 = store, 0 = load.
REQ-009 SHALL have port i_funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port o_rdata  output  32  extended load data.
REQ-011 SHALL have port o_rvalid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port o_misaligned  output  1  misaligned-access flag, valid with o_rvalid.
REQ-013 SHALL have port i_io_sw  input  32  switch inputs, asynchronous to i_clk.
REQ-014 SHALL have port o_io_ledr  output  32  red LED register.
REQ-015 SHALL have port o_io_ledg  output  32  green LED register.

Function
REQ-016 SHALL decode the address map as: 0x0000_0000 to DMEM_WORDS*4-1 = DMEM; 0x1000_0000 = LEDR (R/W); 0x1000_1000 = LEDG (R/W); 0x1001_0000 = SW (read-only); all other addresses unmapped.
REQ-017 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, with o_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on the edge where i_req && o_ready, capturing addr, wdata, wren and funct3 into registers.
REQ-019 SHALL ignore i_req outside IDLE, without queueing; the requester holds the request.
REQ-020 SHALL perform the DMEM/IO read or write on the edge leaving ACCESS, and SHALL register the load data on that same edge.
REQ-021 SHALL drive o_rvalid = 1 for exactly one cycle, in RESP: accept at edge E0, o_rvalid high between E1 and E2, o_ready high again after E2. Throughput is one access per 3 cycles.
REQ-022 SHALL, for loads, select byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU), then sign-extend B/H and zero-extend BU/HU.
REQ-023 SHALL, for stores, write only the addressed byte lane(s); o_rdata = 0 during a store's RESP.
REQ-024 SHALL treat funct3 011, 110 and 111 as W.
REQ-025 SHALL, for unmapped addresses, return 0 on loads and drop stores; a writes to SW is dropped.
REQ-026 SHALL read LEDR/LEDG back as their current register value; byte/half stores update only the addressed lanes.
REQ-027 SHALL pass i_io_sw through a 2-flop synchronizer before it is readable.

Reset
REQ-028 SHALL, while i_reset = 1, force the state to IDLE, o_ready = 1, o_rvalid = 0, o_rdata = 0, o_misaligned = 0, and LEDR = LEDG = 0.
REQ-029 SHALL leave DMEM contents unreset.
REQ-030 SHALL drop any in-flight access when reset asserts before its ACCESS edge: no write occurs and no o_rvalid pulse follows.

Configuration
REQ-031 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat H with addr[0] = 1 and W with addr[1:0] != 0 as misaligned: o_misaligned = 1 with o_rvalid, store suppressed, o_rdata = 0.
REQ-032 SHALL, with LSU_MISALIGN_TRAP_EN undefined, tie o_misaligned to 0 and align misaligned addresses down to the access size.

Structure
REQ-033 SHALL place the funct3 encodings, the FSM state enum and the address-map constants in shared package lsu_pkg.
REQ-034 SHALL instantiate exactly one sub-module, lsu_dmem: a byte-enabled synchronous-read SRAM of DMEM_WORDS x 32.

Verification
REQ-035 SHALL cover: SW 0x0000_0034 to 0x100, then LW 0x100 -> o_rvalid two cycles after accept, o_rdata = 0x0000_0034.
REQ-036 SHALL cover: SW 0x8000_80F0 to 0x200, then LB 0x200 -> 0xFFFF_FFF0; LBU 0x200 -> 0x0000_00F0; LH 0x202 -> 0xFFFF_8000.
REQ-037 SHALL cover: SB 0xAB to 0x1000_0001 after reset -> o_io_ledr = 0x0000_AB00; LW 0x1000_0000 -> 0x0000_AB00.
REQ-038 SHALL cover: i_io_sw = 0x5 held, then LW 0x1001_0000 -> 0x5; LW 0x2000_0000 -> 0; store to 0x2000_0000 changes no state.
REQ-039 SHALL cover: with LSU_MISALIGN_TRAP_EN, SW to 0x102 -> o_misaligned = 1 and word 0x100 unchanged; without the macro, the same store writes 0x100.
REQ-040 SHALL cover: i_reset asserted in ACCESS of SW 0x1 to 0x1000_1000 -> o_io_ledg = 0, no o_rvalid, o_ready = 1 immediately.
